// File: rtl/frame_diff_scanner.sv
// frame_diff_scanner: one-pass compare of the ref and act frame RAMs.
// Emits |act-ref| per pixel, counts motion pixels, and can refresh ref.
module frame_diff_scanner #(
    parameter int NPIX = 4800,
    parameter int AW = 14,
    parameter int DW = 9,
    parameter int CW = 13,
    parameter bit UPDATE_REF = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] thresh,
    input  logic [CW-1:0] min_count,
    output logic [AW-1:0] addr_rd,
    input  logic [DW-1:0] ref_in,
    input  logic [DW-1:0] act_in,
    output logic [AW-1:0] ref_addr_wr,
    output logic [DW-1:0] ref_wr_data,
    output logic          ref_wr_en,
    output logic [DW-1:0] diff_out,
    output logic          diff_valid,
    output logic          motion_pix,
    output logic [CW-1:0] motion_count,
    output logic          motion_flag,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          sampling;
    logic          last;
    logic          hit;
    logic [DW-1:0] thresh_q;
    logic [CW-1:0] min_q;
    logic [DW-1:0] diff_now;
    logic [CW-1:0] cnt_nxt;

    assign last = (addr_rd == AW'(NPIX - 1));

    // Unsigned magnitude: always subtract the smaller from the larger.
    assign diff_now = (act_in >= ref_in) ? (act_in - ref_in)
                                         : (ref_in - act_in);
    assign hit = (diff_now > thresh_q);

    // Saturating count; the saturation point is out of reach at defaults.
    assign cnt_nxt = (hit && (motion_count != '1))
                   ? motion_count + CW'(1)
                   : motion_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        sampling = 1'b0;
        unique case (state)
            IDLE: accept = start;
            SCAN: begin
                busy     = 1'b1;
                sampling = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_rd      <= '0;
            thresh_q     <= '0;
            min_q        <= '0;
            diff_out     <= '0;
            diff_valid   <= 1'b0;
            motion_pix   <= 1'b0;
            motion_count <= '0;
            motion_flag  <= 1'b0;
            ref_wr_en    <= 1'b0;
            ref_addr_wr  <= '0;
            ref_wr_data  <= '0;
        end else begin
            diff_valid <= sampling;
            motion_pix <= sampling & hit;
            ref_wr_en  <= UPDATE_REF & sampling;
            if (accept) begin
                addr_rd      <= '0;
                motion_count <= '0;
                motion_flag  <= 1'b0;
                thresh_q     <= thresh;
                min_q        <= min_count;
            end
            if (sampling) begin
                addr_rd      <= last ? '0 : addr_rd + AW'(1);
                diff_out     <= diff_now;
                motion_count <= cnt_nxt;
                ref_addr_wr  <= addr_rd;
                ref_wr_data  <= act_in;
                if (last) begin
                    motion_flag <= (cnt_nxt >= min_q);
                end
            end
        end
    end

endmodule
